// File: rtl/menu_controller_if.sv
// Keyboard and vsync inputs plus frame-aligned menu/game outputs of menu_controller.
// The master drives keys and vsync. The slave is the controller, which also reports its FSM state.
interface menu_controller_if;
  logic [7:0] key;
  logic       key_valid;
  logic       vsync_in;
  logic       menu_open;
  logic       game_pause;
  logic [1:0] cursor;
  logic [1:0] speed_level;
  logic       speed_update;
  logic       game_restart;
  logic [1:0] state_dbg;

  modport master (
    output key, key_valid, vsync_in,
    input  menu_open, game_pause, cursor, speed_level, speed_update, game_restart, state_dbg
  );

  modport slave (
    input  key, key_valid, vsync_in,
    output menu_open, game_pause, cursor, speed_level, speed_update, game_restart, state_dbg
  );
endinterface

// File: rtl/menu_controller.sv
// Keyboard-driven menu sequencer: every visible change is applied on a vsync rising edge.
// Optional MENU_AUTOCLOSE_EN adds an inactivity frame counter that auto-closes the menu.
module menu_controller #(
  parameter int COOLDOWN_CYCLES = 4,
  parameter int N_ITEMS         = 3,
  parameter int TIMEOUT_FRAMES  = 600
) (
  input logic             clk,
  input logic             rst,
  menu_controller_if.slave bus
);
  typedef enum logic [1:0] {
    ST_CLOSED     = 2'd0,
    ST_OPEN_PEND  = 2'd1,
    ST_OPEN       = 2'd2,
    ST_APPLY_PEND = 2'd3
  } state_e;

  localparam int CW = (COOLDOWN_CYCLES < 1) ? 1 : $clog2(COOLDOWN_CYCLES + 1);
  localparam logic [CW-1:0] COOL_LOAD = CW'(COOLDOWN_CYCLES);
  localparam logic [1:0]    LAST_ITEM = 2'(N_ITEMS - 1);
  localparam logic [2:0]    N_ITEMS_W = 3'(N_ITEMS);
  localparam logic [1:0]    ACT_RESUME  = 2'd0;
  localparam logic [1:0]    ACT_SPEED   = 2'd1;
  localparam logic [1:0]    ACT_RESTART = 2'd2;
  localparam logic [7:0]    KEY_ESC   = 8'h1B;
  localparam logic [7:0]    KEY_UP    = 8'h77;
  localparam logic [7:0]    KEY_DOWN  = 8'h73;
  localparam logic [7:0]    KEY_ENTER = 8'h0D;
  localparam logic [7:0]    KEY_1     = 8'h31;
  localparam logic [7:0]    KEY_2     = 8'h32;
  localparam logic [7:0]    KEY_3     = 8'h33;

  state_e        state_q, state_d;
  logic [CW-1:0] cooldown_q, cooldown_d;
  logic          vsync_q, vsync_d;
  logic          edge_q, edge_d;
  logic [1:0]    cursor_q, cursor_d;
  logic [1:0]    action_q, action_d;
  logic          menu_open_q, menu_open_d;
  logic          game_pause_q, game_pause_d;
  logic [1:0]    speed_q, speed_d;
  logic          speed_update_q, speed_update_d;
  logic          restart_q, restart_d;
`ifdef MENU_AUTOCLOSE_EN
  logic [15:0]   frame_cnt_q, frame_cnt_d;
`endif

  logic       key_accept;
  logic [1:0] digit_sel;
  logic       digit_ok;

  always_comb begin
    key_accept = bus.key_valid && (cooldown_q == '0) &&
                 ((state_q == ST_CLOSED) || (state_q == ST_OPEN));
    // '1'..'3' map to item 0..2 through the low two ASCII bits.
    digit_sel  = bus.key[1:0] - 2'd1;
    digit_ok   = ({1'b0, digit_sel} < N_ITEMS_W);

    state_d        = state_q;
    cursor_d       = cursor_q;
    action_d       = action_q;
    menu_open_d    = menu_open_q;
    game_pause_d   = game_pause_q;
    speed_d        = speed_q;
    speed_update_d = 1'b0;
    restart_d      = 1'b0;
    vsync_d        = bus.vsync_in;
    edge_d         = bus.vsync_in & ~vsync_q;
    cooldown_d     = key_accept ? COOL_LOAD :
                     ((cooldown_q != '0) ? cooldown_q - CW'(1) : '0);
`ifdef MENU_AUTOCLOSE_EN
    frame_cnt_d    = frame_cnt_q;
`endif

    case (state_q)
      ST_CLOSED: begin
        if (key_accept && (bus.key == KEY_ESC)) state_d = ST_OPEN_PEND;
      end
      ST_OPEN_PEND: begin
        if (edge_q) begin
          menu_open_d  = 1'b1;
          game_pause_d = 1'b1;
          cursor_d     = 2'd0;
          state_d      = ST_OPEN;
`ifdef MENU_AUTOCLOSE_EN
          frame_cnt_d  = '0;
`endif
        end
      end
      ST_OPEN: begin
        if (key_accept) begin
`ifdef MENU_AUTOCLOSE_EN
          frame_cnt_d = '0;
`endif
          case (bus.key)
            KEY_ESC: begin
              action_d = ACT_RESUME;
              state_d  = ST_APPLY_PEND;
            end
            KEY_UP:   cursor_d = (cursor_q == 2'd0) ? LAST_ITEM : cursor_q - 2'd1;
            KEY_DOWN: cursor_d = (cursor_q == LAST_ITEM) ? 2'd0 : cursor_q + 2'd1;
            KEY_ENTER: begin
              action_d = cursor_q;
              state_d  = ST_APPLY_PEND;
            end
            KEY_1, KEY_2, KEY_3: begin
              if (digit_ok) begin
                cursor_d = digit_sel;
                action_d = digit_sel;
                state_d  = ST_APPLY_PEND;
              end
            end
            default: ;
          endcase
        end
`ifdef MENU_AUTOCLOSE_EN
        else if (edge_q) begin
          frame_cnt_d = frame_cnt_q + 16'd1;
          if (frame_cnt_d == 16'(TIMEOUT_FRAMES)) begin
            action_d = ACT_RESUME;
            state_d  = ST_APPLY_PEND;
          end
        end
`endif
      end
      ST_APPLY_PEND: begin
        if (edge_q) begin
          // Items beyond RESTART fall through to the RESUME behaviour.
          if (action_q == ACT_SPEED) begin
            speed_d        = speed_q + 2'd1;
            speed_update_d = 1'b1;
            state_d        = ST_OPEN;
`ifdef MENU_AUTOCLOSE_EN
            frame_cnt_d    = '0;
`endif
          end else begin
            restart_d    = (action_q == ACT_RESTART);
            menu_open_d  = 1'b0;
            game_pause_d = 1'b0;
            state_d      = ST_CLOSED;
          end
        end
      end
      default: state_d = ST_CLOSED;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_CLOSED;
      cooldown_q     <= '0;
      vsync_q        <= 1'b0;
      edge_q         <= 1'b0;
      cursor_q       <= 2'd0;
      action_q       <= ACT_RESUME;
      menu_open_q    <= 1'b0;
      game_pause_q   <= 1'b0;
      speed_q        <= 2'd1;
      speed_update_q <= 1'b0;
      restart_q      <= 1'b0;
`ifdef MENU_AUTOCLOSE_EN
      frame_cnt_q    <= '0;
`endif
    end else begin
      state_q        <= state_d;
      cooldown_q     <= cooldown_d;
      vsync_q        <= vsync_d;
      edge_q         <= edge_d;
      cursor_q       <= cursor_d;
      action_q       <= action_d;
      menu_open_q    <= menu_open_d;
      game_pause_q   <= game_pause_d;
      speed_q        <= speed_d;
      speed_update_q <= speed_update_d;
      restart_q      <= restart_d;
`ifdef MENU_AUTOCLOSE_EN
      frame_cnt_q    <= frame_cnt_d;
`endif
    end
  end

  assign bus.menu_open    = menu_open_q;
  assign bus.game_pause   = game_pause_q;
  assign bus.cursor       = cursor_q;
  assign bus.speed_level  = speed_q;
  assign bus.speed_update = speed_update_q;
  assign bus.game_restart = restart_q;
  assign bus.state_dbg    = state_q;
endmodule
